// File: rtl/b_bus_arbiter.sv
// b_bus_arbiter: two-requester Moore arbiter for the shared 2-bit B bus (B1,B0).
// Round-robin with a HOLD_CYCLES time slice; grants, busy and B are decoded
// from registered state.
// Optional macro TIMEOUT_BLK_EN: a lone requester is forced off after
// MAX_GRANT cycles for one IDLE cycle, flagged by a one-cycle outputTimeout.

package b_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } stateT;
endpackage

module b_bus_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned MAX_GRANT   = 8
) (
  input  logic       inputClk,
  input  logic       inputReset,
  input  logic       inputReq0,
  input  logic       inputReq1,
  input  logic [1:0] inputCode0,
  input  logic [1:0] inputCode1,
  output logic       outputGnt0,
  output logic       outputGnt1,
  output logic [1:0] outputB,
  output logic       outputBusy,
  output logic       outputTimeout
);
  import b_bus_arbiter_pkg::*;

`ifdef TIMEOUT_BLK_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  // The counter saturates at the timeout length when timeouts are enabled,
  // otherwise at the end of the slice.
  localparam int unsigned     SAT_CYCLES = TIMEOUT_ON ? MAX_GRANT : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(SAT_CYCLES - 1);
  localparam logic [CNT_W:0]   HOLD_W    = (CNT_W + 1)'(HOLD_CYCLES);

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             lastServed, lastServedNext;
  logic [1:0]       bQ, bNext;
  logic             sliceDone;
  logic             holdExpired;

  // Slice end compared as cycles held (cnt+1) so HOLD_CYCLES=1 needs no special case.
  assign sliceDone   = ({1'b0, cnt} + (CNT_W + 1)'(1)) >= HOLD_W;
  assign holdExpired = TIMEOUT_ON && (cnt == CNT_SAT);

  // Next-state, counter, pointer and bus value selection.
  always_comb begin
    stateNext      = state;
    cntNext        = '0;
    lastServedNext = lastServed;
    bNext          = '0;

    unique case (state)
      IDLE: begin
        if (inputReq0 && inputReq1) stateNext = lastServed ? G0 : G1;
        else if (inputReq0)         stateNext = G0;
        else if (inputReq1)         stateNext = G1;
        else                        stateNext = IDLE;
      end
      G0: begin
        if (!inputReq0)                    stateNext = inputReq1 ? G1 : IDLE;
        else if (inputReq1 && sliceDone)   stateNext = G1;
        else if (!inputReq1 && holdExpired) stateNext = IDLE;
        else                               stateNext = G0;
      end
      G1: begin
        if (!inputReq1)                    stateNext = inputReq0 ? G0 : IDLE;
        else if (inputReq0 && sliceDone)   stateNext = G0;
        else if (!inputReq0 && holdExpired) stateNext = IDLE;
        else                               stateNext = G1;
      end
      default: stateNext = IDLE;
    endcase

    if (stateNext != IDLE && stateNext == state)
      cntNext = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

    case (stateNext)
      G0: begin
        bNext          = inputCode0;
        lastServedNext = 1'b0;
      end
      G1: begin
        bNext          = inputCode1;
        lastServedNext = 1'b1;
      end
      default: bNext = '0;
    endcase
  end

  // State, slice counter, last-served pointer and bus register.
  always_ff @(posedge inputClk) begin
    if (inputReset) begin
      state      <= IDLE;
      cnt        <= '0;
      lastServed <= 1'b1;
      bQ         <= '0;
    end else begin
      state      <= stateNext;
      cnt        <= cntNext;
      lastServed <= lastServedNext;
      bQ         <= bNext;
    end
  end

`ifdef TIMEOUT_BLK_EN
  logic timeoutQ;

  // Leaving a grant for IDLE while still requesting can only be a forced release.
  always_ff @(posedge inputClk) begin
    if (inputReset) timeoutQ <= 1'b0;
    else timeoutQ <= (stateNext == IDLE) &&
                     ((state == G0 && inputReq0) || (state == G1 && inputReq1));
  end

  assign outputTimeout = timeoutQ;
`else
  assign outputTimeout = 1'b0;
`endif

  assign outputGnt0 = (state == G0);
  assign outputGnt1 = (state == G1);
  assign outputBusy = (state == G0) || (state == G1);
  assign outputB    = bQ;

endmodule

// File: tb/tb_b_bus_arbiter.sv
// tb_b_bus_arbiter: directed and randomized checks of b_bus_arbiter against a
// cycle-level ownership model; two instances (slice 4 and slice 1).
module tb_b_bus_arbiter;
  import b_bus_arbiter_pkg::*;

`ifdef TIMEOUT_BLK_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAX_GRANT = 8;

  logic       clk;
  logic       inputReset, inputReq0, inputReq1;
  logic [1:0] inputCode0, inputCode1;
  logic       gnt0A, gnt1A, busyA, toA;
  logic [1:0] bA;
  logic       gnt0B, gnt1B, busyB, toB;
  logic [1:0] bB;

  int numCompared   = 0;
  int numMismatched = 0;

  int         owner[2];
  int         held[2];
  int         last[2];
  bit         tout[2];
  logic [1:0] expB[2];
  int         holdOf[2];

  b_bus_arbiter #(.HOLD_CYCLES(4), .CNT_W(3), .MAX_GRANT(MAX_GRANT)) dut0 (
    .inputClk(clk), .inputReset(inputReset),
    .inputReq0(inputReq0), .inputReq1(inputReq1),
    .inputCode0(inputCode0), .inputCode1(inputCode1),
    .outputGnt0(gnt0A), .outputGnt1(gnt1A), .outputB(bA),
    .outputBusy(busyA), .outputTimeout(toA)
  );

  b_bus_arbiter #(.HOLD_CYCLES(1), .CNT_W(3), .MAX_GRANT(MAX_GRANT)) dut1 (
    .inputClk(clk), .inputReset(inputReset),
    .inputReq0(inputReq0), .inputReq1(inputReq1),
    .inputCode0(inputCode0), .inputCode1(inputCode1),
    .outputGnt0(gnt0B), .outputGnt1(gnt1B), .outputB(bB),
    .outputBusy(busyB), .outputTimeout(toB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Ownership model: who holds the bus and for how many whole cycles.
  task automatic modelStep(input int i, input bit rst, input bit r0, input bit r1,
                           input logic [1:0] c0, input logic [1:0] c1, input bit frc);
    int nxt;
    int k;
    int j;
    bit r[2];
    r[0] = r0;
    r[1] = r1;
    tout[i] = 1'b0;
    if (rst) begin
      owner[i] = -1; held[i] = 0; last[i] = 1; expB[i] = 2'b00;
      return;
    end
    if (frc) begin
      owner[i] = -1; held[i] = 0; expB[i] = 2'b00;
      return;
    end
    if (owner[i] < 0) begin
      if (r0 && r1)  nxt = 1 - last[i];
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
      else           nxt = -1;
    end else begin
      k = owner[i];
      j = 1 - k;
      if (!r[k])                                        nxt = r[j] ? j : -1;
      else if (r[j] && held[i] >= holdOf[i])            nxt = j;
      else if (TO_EN && !r[j] && held[i] >= MAX_GRANT) begin
        nxt = -1;
        tout[i] = 1'b1;
      end
      else                                              nxt = k;
    end
    if (nxt >= 0 && nxt == owner[i]) held[i]++;
    else held[i] = (nxt >= 0) ? 1 : 0;
    if (nxt >= 0) last[i] = nxt;
    owner[i] = nxt;
    expB[i] = (nxt == 0) ? c0 : (nxt == 1) ? c1 : 2'b00;
  endtask

  task automatic compareInst(input int i, input logic g0, input logic g1, input logic busy,
                             input logic [1:0] b, input logic to);
    string s;
    s = $sformatf("h%0d@%0t", holdOf[i], $time);
    checkVal({"gnt0 ", s}, 32'(g0), 32'(owner[i] == 0));
    checkVal({"gnt1 ", s}, 32'(g1), 32'(owner[i] == 1));
    checkVal({"busy ", s}, 32'(busy), 32'(owner[i] >= 0));
    checkVal({"bus ", s}, 32'(b), 32'(expB[i]));
    checkVal({"timeout ", s}, 32'(to), 32'(tout[i]));
    checkVal({"exclusive ", s}, 32'(g0 & g1), 32'(0));
  endtask

  task automatic cycle(input bit rst, input bit r0, input bit r1,
                       input logic [1:0] c0, input logic [1:0] c1, input bit frc);
    @(negedge clk);
    inputReset = rst;
    inputReq0  = r0;
    inputReq1  = r1;
    inputCode0 = c0;
    inputCode1 = c1;
    if (frc) begin
      force dut0.state = stateT'(2'b11);
      #1;
      release dut0.state;
    end
    @(posedge clk);
    modelStep(0, rst, r0, r1, c0, c1, frc);
    modelStep(1, rst, r0, r1, c0, c1, 1'b0);
    #1;
    compareInst(0, gnt0A, gnt1A, busyA, bA, toA);
    compareInst(1, gnt0B, gnt1B, busyB, bB, toB);
  endtask

  initial begin
    int p0;
    int p1;
    bit rst;
    bit r0;
    bit r1;
    logic [1:0] c0;
    logic [1:0] c1;
    holdOf[0] = 4;
    holdOf[1] = 1;
    for (int unsigned i = 0; i < 2; i++) begin
      owner[i] = -1; held[i] = 0; last[i] = 1; tout[i] = 1'b0; expB[i] = 2'b00;
    end
    inputReset = 1'b1; inputReq0 = 1'b0; inputReq1 = 1'b0;
    inputCode0 = 2'b00; inputCode1 = 2'b00;

    cycle(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    // Single request, then drop.
    cycle(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    // Reset, then both contend: slices rotate.
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    repeat (12) cycle(1'b0, 1'b1, 1'b1, 2'b01, 2'b11, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    // Direct handover G1 -> G0 with no bubble.
    cycle(1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'b11, 2'b10, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    // Reset during the second cycle of G0.
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 2'b10, 2'b11, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 2'b10, 2'b11, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    // Lone requester held long enough to reach the timeout, if enabled.
    repeat (12) cycle(1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    // Illegal state recovery.
    cycle(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);

    // Randomized phases with varying request density.
    for (int blk = 0; blk < 12; blk++) begin
      p0 = (blk % 3 == 0) ? 20 : (blk % 3 == 1) ? 60 : 95;
      p1 = (blk % 4 == 0) ? 95 : (blk % 4 == 1) ? 15 : (blk % 4 == 2) ? 60 : 0;
      for (int n = 0; n < 35; n++) begin
        rst = ($urandom_range(0, 59) == 0);
        r0  = ($urandom_range(0, 99) < p0);
        r1  = ($urandom_range(0, 99) < p1);
        c0  = 2'($urandom_range(0, 3));
        c1  = 2'($urandom_range(0, 3));
        cycle(rst, r0, r1, c0, c1, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/b_bus_arbiter.md
Name: b_bus_arbiter

Overview:
- Moore-style two-requester arbiter that shares the 2-bit B output bus (B1,B0) of the control stage.
- Each requester presents a request and the 2-bit code it wants driven. The arbiter grants one requester at a time.
- A granted requester keeps the grant for a time-slice quantum while the other requester is waiting, then the grant rotates round-robin.
- Sits between the stimulus/requester logic and the downstream consumer of B.

Parameters:
- HOLD_CYCLES, 4, time-slice quantum in cycles before a waiting requester may preempt; legal range 1..2^CNT_W.
- CNT_W, 3, width of the slice/timeout counter.
- MAX_GRANT, 8, timeout length in cycles; used only with TIMEOUT_BLK_EN; must be ≤ 2^CNT_W.

Ports:
- inputClk  in  1  clock; all state updates on its rising edge.
- inputReset  in  1  synchronous, active-high reset.
- inputReq0  in  1  request from requester 0.
- inputReq1  in  1  request from requester 1.
- inputCode0  in  2  B code requested by requester 0.
- inputCode1  in  2  B code requested by requester 1.
- outputGnt0  out  1  grant to requester 0 (registered).
- outputGnt1  out  1  grant to requester 1 (registered).
- outputB  out  2  arbitrated bus value; [1]=B1, [0]=B0 (registered).
- outputBusy  out  1  high whenever any grant is active.
- outputTimeout  out  1  one-cycle pulse on forced release; constant 0 without TIMEOUT_BLK_EN.

Behaviour:
- Reset:
  - inputReset sampled high at a rising edge → state IDLE, slice counter 0, last-served pointer = 1 (requester 0 wins the first tie).
  - All outputs are 0 in the following cycle.
  - Reset overrides everything, including an active grant mid-slice; the grant drops the cycle after reset is sampled.
- States, with encoding and Moore outputs:
  - IDLE=00: Gnt0=0, Gnt1=0, Busy=0, B=00.
  - G0=01: Gnt0=1, Busy=1.
  - G1=10: Gnt1=1, Busy=1.
  - 11 is illegal and recovers to IDLE on the next edge.
- Outputs are decoded from registered state only. Request-to-grant latency is exactly 1 cycle.
- outputB:
  - In G0, registered from inputCode0 every cycle; in G1, from inputCode1. The code therefore appears 1 cycle after presentation.
  - In IDLE, B=00.
  - On entering Gk, B shows inputCodek sampled at the same edge as the grant.
- IDLE transitions:
  - Only Req0 → G0.
  - Only Req1 → G1.
  - Both → grant the requester not last served.
  - Neither → stay in IDLE.
- Gk transitions (k = 0/1, j = other requester), evaluated each edge in priority order:
  - (a) Reqk low: go to Gj if Reqj is high, else IDLE.
  - (b) Reqj high and counter == HOLD_CYCLES-1: go to Gj (preemption).
  - (c) Otherwise stay in Gk.
- Handover Gk→Gj is direct, with no IDLE bubble. Gntk and Gntj are never high in the same cycle.
- Slice counter:
  - Cleared to 0 on every entry to G0/G1 and in IDLE.
  - Increments each cycle in Gk.
  - Saturates at HOLD_CYCLES-1 while Reqj is low; without TIMEOUT_BLK_EN it never wraps.
- Last-served pointer updates to k on every entry to Gk.
- HOLD_CYCLES=1: a waiting requester preempts after every grant cycle, giving strict alternation.
- Requester drops and re-raises in the same cycle as the other's request: treated per the sampled values only; no request memory is kept.

Optional Feature:
- Macro: TIMEOUT_BLK_EN.
- When defined:
  - The counter keeps counting while alone, saturating at MAX_GRANT-1.
  - If Gk has been held MAX_GRANT cycles with Reqj low, the next edge forces IDLE for exactly 1 cycle and pulses outputTimeout for that cycle.
  - Requester k is then masked for that IDLE cycle and may be re-granted afterwards.
  - If Reqj rises before the timeout, rule (b) applies as normal.
- When undefined:
  - A lone requester holds the grant indefinitely.
  - outputTimeout is tied to 0.
  - The counter saturates at HOLD_CYCLES-1.

Test Plan:
- Reset then Req0=1, Code0=10 → cycle+1: Gnt0=1, Busy=1, B=10. Drop Req0 → next cycle: IDLE, B=00.
- Req0 and Req1 both rise together from IDLE after reset → Gnt0 first. Keep both high with HOLD_CYCLES=4 → Gnt0 for 4 cycles, then Gnt1 for 4 cycles, then Gnt0; no cycle has both grants set.
- In G1 with Req0=0, Req1 falls while Req0 rises → next cycle Gnt0=1, no IDLE bubble, B = Code0.
- Assert inputReset at the 2nd cycle of G0 → next cycle all outputs 0. After reset, with both requesting, Gnt0 wins.
- With TIMEOUT_BLK_EN and MAX_GRANT=8, Req1 held alone → 8 cycles Gnt1, then 1 cycle IDLE with outputTimeout=1, then Gnt1 again. Without the macro: Gnt1 stays high and outputTimeout stays 0.
- Force state to 11 via a bench hook → next edge IDLE with all outputs 0.
